// File: rtl/ir_ac_scheduler.sv
// ir_ac_scheduler: arbitrates AC key requests, updates the held settings and
// sequences repeated IR frames (with inter-frame gaps) through the transmitter.
module ir_ac_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REPEAT_N   = 2,
  parameter int GAP_CYCLES = 4_000_000,
  parameter int TX_TIMEOUT = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic        tx_ready,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [34:0] data35,
  output logic [31:0] data32,
  output logic        power,
  output logic [4:0]  temp,
  output logic [1:0]  mode,
  output logic        busy,
  output logic        frame_sent,
  output logic        err
);

  localparam int MAX_CNT = (GAP_CYCLES > TX_TIMEOUT) ? GAP_CYCLES : TX_TIMEOUT;
  // CLK_HZ only documents the cycle figures; a non-positive value widens nothing useful.
  localparam int CW = $clog2(MAX_CNT + 1) + ((CLK_HZ > 0) ? 0 : 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TX_TIMEOUT - 1);
  localparam logic [2:0]    REP_INIT = 3'(REPEAT_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [3:0]      r_pending;
  logic [1:0]      r_cmd;
  logic            r_power;
  logic [4:0]      r_temp;
  logic [1:0]      r_mode;
  logic [34:0]     r_data35;
  logic [31:0]     r_data32;
  logic [2:0]      r_rep;
  logic [CW-1:0]   r_cnt;
  logic            r_frame_sent;
  logic            r_err;

  logic            w_any;
  logic [1:0]      w_idx;
  logic [3:0]      w_clear;
  logic [3:0]      w_csum;

  assign w_any = |r_pending;

  always_comb begin
    w_idx = 2'd0;
    if (r_pending[0])      w_idx = 2'd0;
    else if (r_pending[1]) w_idx = 2'd1;
    else if (r_pending[2]) w_idx = 2'd2;
    else if (r_pending[3]) w_idx = 2'd3;
  end

  assign w_clear = (r_state == S_IDLE && w_any) ? (4'b0001 << w_idx) : 4'b0000;

  // temp stays within 16..30, so temp-16 is simply its low nibble
  assign w_csum = {r_power, 1'b0, r_mode} + r_temp[3:0] + 4'd10;

  // New requests are ORed in after the clear so a same-cycle set wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= 4'b0000;
    else     r_pending <= (r_pending & ~w_clear) | req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmd        <= 2'd0;
      r_power      <= 1'b0;
      r_temp       <= 5'd26;
      r_mode       <= 2'd1;
      r_data35     <= '0;
      r_data32     <= '0;
      r_rep        <= 3'd0;
      r_cnt        <= '0;
      r_frame_sent <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_sent <= 1'b0;
      r_err        <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cmd   <= w_idx;
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_state <= S_IDLE;
          unique case (r_cmd)
            2'd0: begin
              r_power <= ~r_power;
              r_state <= S_LOAD;
            end
            2'd1: if (r_power && r_temp != 5'd30) begin
              r_temp  <= r_temp + 5'd1;
              r_state <= S_LOAD;
            end
            2'd2: if (r_power && r_temp != 5'd16) begin
              r_temp  <= r_temp - 5'd1;
              r_state <= S_LOAD;
            end
            2'd3: if (r_power) begin
              r_mode  <= r_mode + 2'd1;
              r_state <= S_LOAD;
            end
          endcase
        end
        S_LOAD: begin
          r_data35 <= {23'h140250, r_temp[3:0], 4'h0, r_power, 1'b0, r_mode};
          r_data32 <= {w_csum, 28'h0};
          r_rep    <= REP_INIT;
          r_state  <= S_START;
        end
        S_START: begin
          if (tx_ready) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            r_rep        <= r_rep - 3'd1;
            r_frame_sent <= (r_rep == 3'd1);
            r_cnt        <= '0;
            r_state      <= S_GAP;
          end else if (r_cnt == TO_LAST) begin
            // Abandon the remaining repeats but still honour the gap
            r_err   <= 1'b1;
            r_rep   <= 3'd0;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= (r_rep != 3'd0) ? S_START : S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_start   = (r_state == S_START) && tx_ready;
  assign data35     = r_data35;
  assign data32     = r_data32;
  assign power      = r_power;
  assign temp       = r_temp;
  assign mode       = r_mode;
  assign busy       = (r_state != S_IDLE) || w_any;
  assign frame_sent = r_frame_sent;
  assign err        = r_err;

endmodule
